// File: rtl/binary_merger_stream.sv
// Two-way streaming merger for sorted sparse-fiber coordinate streams.
// Each input is buffered in a small FIFO; a merge FSM picks the smaller
// head (optionally summing equal coordinates) and loads a registered
// output stage, so instances can be chained into a merge tree.
module binary_merger_stream #(
  parameter int MERGER_COORD_BITS = 32,
  parameter int VALUE_BITS        = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter int COMBINE_EQUAL     = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [1:0]                     in_valid,
  output logic [1:0]                     in_ready,
  input  logic [2*MERGER_COORD_BITS-1:0] in_coord,
  input  logic [2*VALUE_BITS-1:0]        in_value,
  input  logic [1:0]                     in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MERGER_COORD_BITS-1:0]   out_coord,
  output logic [VALUE_BITS-1:0]          out_value,
  output logic                           out_last
);

  localparam int CB = MERGER_COORD_BITS;
  localparam int VB = VALUE_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CB + VB + 1;

  typedef enum logic [1:0] {
    ST_MERGE  = 2'd0,
    ST_DRAIN0 = 2'd1,
    ST_DRAIN1 = 2'd2
  } state_t;

  // FIFO status and head views (input i in slice i)
  logic [1:0]      w_empty;
  logic [1:0]      w_full;
  logic [1:0]      w_pop;
  logic [2*CB-1:0] w_head_coord;
  logic [2*VB-1:0] w_head_value;
  logic [1:0]      w_head_last;

  // Merge decision
  state_t          r_state;
  state_t          w_next_state;
  logic            w_can_load;
  logic            w_do_load;
  logic [CB-1:0]   w_sel_coord;
  logic [VB-1:0]   w_sel_value;
  logic            w_sel_last;
  logic [CB-1:0]   w_c0;
  logic [CB-1:0]   w_c1;
  logic [VB-1:0]   w_v0;
  logic [VB-1:0]   w_v1;
  logic            w_l0;
  logic            w_l1;
  logic [VB-1:0]   w_sum;

  // Output stage
  logic            r_out_valid;
  logic [CB-1:0]   r_out_coord;
  logic [VB-1:0]   r_out_value;
  logic            r_out_last;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [EW-1:0] w_head;
    logic          w_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty[g] = (r_wr_ptr == r_rd_ptr);
    assign w_full[g]  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // ready depends only on the stored fill level, never on a same-cycle pop
    assign w_push     = in_valid[g] & ~w_full[g];
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    assign w_head_coord[g*CB +: CB] = w_head[CB-1:0];
    assign w_head_value[g*VB +: VB] = w_head[CB +: VB];
    assign w_head_last[g]           = w_head[EW-1];

    // Advance write/read pointers on push and pop; reset discards contents.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_wr_ptr <= {(AW+1){1'b0}};
        r_rd_ptr <= {(AW+1){1'b0}};
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
        end
        if (w_pop[g]) begin
          r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
      end
    end

    // Entry storage; data needs no reset because the pointers gate visibility.
    always_ff @(posedge clock) begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {in_last[g], in_value[g*VB +: VB], in_coord[g*CB +: CB]};
      end
    end
  end

  assign in_ready = ~w_full;

  assign w_c0  = w_head_coord[CB-1:0];
  assign w_c1  = w_head_coord[2*CB-1:CB];
  assign w_v0  = w_head_value[VB-1:0];
  assign w_v1  = w_head_value[2*VB-1:VB];
  assign w_l0  = w_head_last[0];
  assign w_l1  = w_head_last[1];
  // Carry out of the sum is intentionally dropped (modular add).
  assign w_sum = w_v0 + w_v1;

  // The output register can take a new element when empty or being drained.
  assign w_can_load = ~r_out_valid | out_ready;

  // Merge decision: choose which head(s) to pop, what to emit, and next state.
  always_comb begin
    w_pop        = 2'b00;
    w_do_load    = 1'b0;
    w_sel_coord  = w_c0;
    w_sel_value  = w_v0;
    w_sel_last   = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ST_MERGE: begin
        if (w_can_load && !w_empty[0] && !w_empty[1]) begin
          w_do_load = 1'b1;
          if (w_c0 < w_c1) begin
            w_pop = 2'b01;
            if (w_l0) begin
              w_next_state = ST_DRAIN1;
            end else begin
              w_next_state = ST_MERGE;
            end
          end else if (w_c1 < w_c0) begin
            w_pop       = 2'b10;
            w_sel_coord = w_c1;
            w_sel_value = w_v1;
            if (w_l1) begin
              w_next_state = ST_DRAIN0;
            end else begin
              w_next_state = ST_MERGE;
            end
          end else if (COMBINE_EQUAL != 0) begin
            w_pop       = 2'b11;
            w_sel_value = w_sum;
            if (w_l0 && w_l1) begin
              w_sel_last   = 1'b1;
              w_next_state = ST_MERGE;
            end else if (w_l0) begin
              w_next_state = ST_DRAIN1;
            end else if (w_l1) begin
              w_next_state = ST_DRAIN0;
            end else begin
              w_next_state = ST_MERGE;
            end
          end else begin
            // Equal coordinates without combining: input 0 goes first.
            w_pop = 2'b01;
            if (w_l0) begin
              w_next_state = ST_DRAIN1;
            end else begin
              w_next_state = ST_MERGE;
            end
          end
        end else begin
          w_do_load = 1'b0;
        end
      end
      ST_DRAIN0: begin
        if (w_can_load && !w_empty[0]) begin
          w_do_load   = 1'b1;
          w_pop       = 2'b01;
          w_sel_coord = w_c0;
          w_sel_value = w_v0;
          w_sel_last  = w_l0;
          if (w_l0) begin
            w_next_state = ST_MERGE;
          end else begin
            w_next_state = ST_DRAIN0;
          end
        end else begin
          w_do_load = 1'b0;
        end
      end
      ST_DRAIN1: begin
        if (w_can_load && !w_empty[1]) begin
          w_do_load   = 1'b1;
          w_pop       = 2'b10;
          w_sel_coord = w_c1;
          w_sel_value = w_v1;
          w_sel_last  = w_l1;
          if (w_l1) begin
            w_next_state = ST_MERGE;
          end else begin
            w_next_state = ST_DRAIN1;
          end
        end else begin
          w_do_load = 1'b0;
        end
      end
      default: begin
        w_next_state = ST_MERGE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_MERGE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered output stage: load on a decision, hold while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_coord <= {CB{1'b0}};
      r_out_value <= {VB{1'b0}};
      r_out_last  <= 1'b0;
    end else if (w_do_load) begin
      r_out_valid <= 1'b1;
      r_out_coord <= w_sel_coord;
      r_out_value <= w_sel_value;
      r_out_last  <= w_sel_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_coord = r_out_coord;
  assign out_value = r_out_value;
  assign out_last  = r_out_last;

endmodule
